// File: rtl/simon_pkt_unpack.sv
// simon_pkt_unpack: validates SIMON host packets (handshake pkt_*) and routes them as a key (key_*) or one/two data blocks (data_*), with sticky error flags (err_*).
module simon_pkt_unpack #(
  parameter int N = 32,
  parameter int M = 4,
  parameter logic [3:0] MODE = 4'd3,
  localparam int PKT_W = (N/2+2)*8
) (
  input  logic             clk,
  input  logic             nR,
  input  logic [PKT_W-1:0] pkt_in,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  output logic [M*N-1:0]   key_out,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [2*N-1:0]   data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [7:0]       info_out,
  output logic [7:0]       count_exp,
  output logic             err_count,
  output logic             err_mode,
  output logic             err_dir,
  input  logic             err_clr
);
  typedef enum logic [1:0] {IDLE, CHECK, EMIT_A, EMIT_B} state_t;
  state_t state_q, state_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [M*N-1:0] key_out_q, key_out_d;
  logic [2*N-1:0] data_out_q, data_out_d;
  logic [7:0] info_out_q, info_out_d, count_exp_q, count_exp_d, cnt, info;
  logic key_valid_q, key_valid_d, data_valid_q, data_valid_d;
  logic err_count_q, err_count_d, err_mode_q, err_mode_d, err_dir_q, err_dir_d;
  logic bad_mode, bad_dir, two;
  assign cnt = pkt_q[4*N +: 8];
  assign info = pkt_q[4*N+8 +: 8];
  assign bad_mode = info[3:0] != MODE;
  assign bad_dir = info[4];
  assign two = !info[5] && info[7];
  assign pkt_ready = nR && state_q == IDLE;
  assign key_out = key_out_q;
  assign key_valid = key_valid_q;
  assign data_out = data_out_q;
  assign data_valid = data_valid_q;
  assign info_out = info_out_q;
  assign count_exp = count_exp_q;
  assign err_count = err_count_q;
  assign err_mode = err_mode_q;
  assign err_dir = err_dir_q;
  always_comb begin
    state_d = state_q;
    pkt_d = pkt_q;
    key_out_d = key_out_q;
    data_out_d = data_out_q;
    info_out_d = info_out_q;
    key_valid_d = key_valid_q;
    data_valid_d = data_valid_q;
    count_exp_d = count_exp_q;
    err_count_d = err_count_q && !err_clr;
    err_mode_d = err_mode_q && !err_clr;
    err_dir_d = err_dir_q && !err_clr;
    case (state_q)
      IDLE: if (pkt_valid && pkt_ready) begin
        pkt_d = pkt_in;
        state_d = CHECK;
      end
      CHECK: begin
        count_exp_d = cnt + 8'd1;
        err_count_d = err_count_d || cnt != count_exp_q;
        err_mode_d = err_mode_d || bad_mode;
        err_dir_d = err_dir_d || bad_dir;
        state_d = (bad_mode || bad_dir) ? IDLE : EMIT_A;
        if (!(bad_mode || bad_dir)) begin
          key_out_d = pkt_q[M*N-1:0];
          data_out_d = two ? pkt_q[2*N-1:0] : pkt_q[4*N-1:2*N];
          info_out_d = info;
        end
      end
      EMIT_A: if (!key_valid_q && !data_valid_q) begin
        key_valid_d = info[5];
        data_valid_d = !info[5];
      end else if (key_valid_q ? key_ready : data_ready) begin
        key_valid_d = 1'b0;
        data_valid_d = two;
        data_out_d = two ? pkt_q[4*N-1:2*N] : data_out_q;
        state_d = two ? EMIT_B : IDLE;
      end
      default: if (data_ready) begin
        data_valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!nR) begin
      state_q <= IDLE;
      pkt_q <= '0;
      key_out_q <= '0;
      data_out_q <= '0;
      info_out_q <= '0;
      key_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      count_exp_q <= '0;
      err_count_q <= 1'b0;
      err_mode_q <= 1'b0;
      err_dir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pkt_q <= pkt_d;
      key_out_q <= key_out_d;
      data_out_q <= data_out_d;
      info_out_q <= info_out_d;
      key_valid_q <= key_valid_d;
      data_valid_q <= data_valid_d;
      count_exp_q <= count_exp_d;
      err_count_q <= err_count_d;
      err_mode_q <= err_mode_d;
      err_dir_q <= err_dir_d;
    end
  end
endmodule

// File: tb/tb_simon_pkt_unpack.sv
// tb_simon_pkt_unpack: directed scoreboard bench for simon_pkt_unpack
module tb_simon_pkt_unpack;
  localparam int N = 32;
  localparam int M = 4;
  localparam int PKT_W = (N/2+2)*8;
  logic clk = 1'b0, nR = 1'b0, pkt_valid = 1'b0, key_ready = 1'b0, data_ready = 1'b0, err_clr = 1'b0;
  logic [PKT_W-1:0] pkt_in = '0;
  logic pkt_ready, key_valid, data_valid, err_count, err_mode, err_dir;
  logic [M*N-1:0] key_out;
  logic [2*N-1:0] data_out;
  logic [7:0] info_out, count_exp;
  typedef struct {
    logic key;
    logic [255:0] val;
    logic [7:0] info;
  } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0, lat = 0;
  logic [7:0] m_cnt = 8'd0;
  logic m_ec = 1'b0, m_em = 1'b0, m_ed = 1'b0;
  always #5 clk = ~clk;
  simon_pkt_unpack #(.N(N), .M(M), .MODE(4'd3)) dut (
    .clk(clk), .nR(nR), .pkt_in(pkt_in), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .key_out(key_out), .key_valid(key_valid), .key_ready(key_ready),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .info_out(info_out), .count_exp(count_exp),
    .err_count(err_count), .err_mode(err_mode), .err_dir(err_dir), .err_clr(err_clr)
  );
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [255:0] cur();
    return key_valid ? 256'(key_out) : 256'(data_out);
  endfunction
  task automatic chk_model(input string tag);
    chk({tag, "_count_exp"}, 256'(count_exp), 256'(m_cnt));
    chk({tag, "_err_count"}, 256'(err_count), 256'(m_ec));
    chk({tag, "_err_mode"}, 256'(err_mode), 256'(m_em));
    chk({tag, "_err_dir"}, 256'(err_dir), 256'(m_ed));
  endtask
  task automatic send(input logic [7:0] info, input logic [7:0] cnt,
                      input logic [N-1:0] w0, input logic [N-1:0] w1,
                      input logic [N-1:0] w2, input logic [N-1:0] w3);
    int c = 0;
    exp_t e;
    if (info[3:0] == 4'd3 && !info[4]) begin
      e.info = info;
      e.key = info[5];
      if (info[5]) e.val = 256'({w3, w2, w1, w0});
      else begin
        if (info[7]) begin
          e.val = 256'({w1, w0});
          sb.push_back(e);
        end
        e.val = 256'({w3, w2});
      end
      sb.push_back(e);
    end
    m_ec = m_ec || cnt != m_cnt;
    m_em = m_em || info[3:0] != 4'd3;
    m_ed = m_ed || info[4];
    m_cnt = cnt + 8'd1;
    while (!pkt_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("pkt_ready_wait", 256'(c < 20), 256'(1));
    pkt_in = {info, cnt, w3, w2, w1, w0};
    pkt_valid = 1'b1;
    @(negedge clk);
    pkt_valid = 1'b0;
    pkt_in = PKT_W'({$urandom, $urandom, $urandom, $urandom});
  endtask
  task automatic take(input int hold, output int l);
    int c = 0;
    exp_t e;
    while (!(key_valid || data_valid) && c < 20) begin
      @(negedge clk);
      c++;
    end
    l = c;
    chk("valid_wait", 256'(c < 20), 256'(1));
    chk("sb_nonempty", 256'(sb.size() != 0), 256'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (hold) begin
        chk("hold_valid", 256'(key_valid || data_valid), 256'(1));
        chk("hold_val", cur(), e.val);
        @(negedge clk);
      end
      chk("onehot", 256'(key_valid && data_valid), 256'(0));
      chk("kind_key", 256'(key_valid), 256'(e.key));
      chk("value", cur(), e.val);
      chk("info_out", 256'(info_out), 256'(e.info));
    end
    key_ready = 1'b1;
    data_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    data_ready = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pkt_ready", 256'(pkt_ready), 256'(0));
    chk("rst_key_valid", 256'(key_valid), 256'(0));
    chk("rst_data_valid", 256'(data_valid), 256'(0));
    chk("rst_key_out", 256'(key_out), 256'(0));
    chk("rst_data_out", 256'(data_out), 256'(0));
    chk("rst_info_out", 256'(info_out), 256'(0));
    chk_model("rst");
    nR = 1'b1;
    @(negedge clk);
    chk("idle_ready", 256'(pkt_ready), 256'(1));
    send(8'h23, 8'd0, 32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004);
    take(0, lat);
    chk("key_latency", 256'(lat), 256'(2));
    chk("key_done_valid", 256'(key_valid), 256'(0));
    chk_model("key");
    send(8'h03, 8'd1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    take(5, lat);
    chk("single_latency", 256'(lat), 256'(2));
    chk("single_idle_ready", 256'(pkt_ready), 256'(1));
    chk("single_valid_drop", 256'(data_valid), 256'(0));
    chk_model("single");
    send(8'h83, 8'd2, 32'h5555_0000, 32'h6666_0001, 32'h7777_0002, 32'h8888_0003);
    take(0, lat);
    chk("two_latency", 256'(lat), 256'(2));
    chk("two_ready_low", 256'(pkt_ready), 256'(0));
    take(1, lat);
    chk("two_b_immediate", 256'(lat), 256'(0));
    chk("two_ready_high", 256'(pkt_ready), 256'(1));
    chk("two_valid_drop", 256'(data_valid), 256'(0));
    chk_model("two");
    send(8'h03, 8'd7, 32'h0BAD_0000, 32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003);
    take(0, lat);
    chk("mismatch_latency", 256'(lat), 256'(2));
    chk_model("mismatch");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ec = 1'b0;
    m_em = 1'b0;
    m_ed = 1'b0;
    chk_model("clear");
    send(8'h05, 8'd8, 32'h1, 32'h2, 32'h3, 32'h4);
    chk("mode_check_busy", 256'(pkt_ready), 256'(0));
    @(negedge clk);
    chk("mode_ready_back", 256'(pkt_ready), 256'(1));
    chk("mode_no_valid", 256'(key_valid || data_valid), 256'(0));
    chk_model("mode");
    send(8'h13, 8'hFF, 32'h5, 32'h6, 32'h7, 32'h8);
    @(negedge clk);
    chk("dir_ready_back", 256'(pkt_ready), 256'(1));
    @(negedge clk);
    chk("dir_no_valid", 256'(key_valid || data_valid), 256'(0));
    chk_model("dir_wrap");
    send(8'h03, 8'd0, 32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003);
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", 256'(data_valid), 256'(1));
    nR = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 256'(data_valid), 256'(0));
    chk("mid_rst_ready", 256'(pkt_ready), 256'(0));
    chk("mid_rst_pending", 256'(sb.size()), 256'(1));
    sb.delete();
    m_cnt = 8'd0;
    m_ec = 1'b0;
    m_em = 1'b0;
    m_ed = 1'b0;
    chk_model("mid_rst");
    nR = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 256'(pkt_ready), 256'(1));
    send(8'h03, 8'd0, 32'h9, 32'hA, 32'hB, 32'hC);
    take(0, lat);
    chk_model("post_rst");
    chk("sb_empty", 256'(sb.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
